// File: rtl/vcache_stat_print_sequencer.sv
// Round-robin arbiter that replays a granted stat tag to each vcache
// profiler in turn, one print pulse per vcache with a fixed idle gap.
module vcache_stat_print_sequencer #(
    parameter int num_req_p    = 2,
    parameter int num_vcache_p = 8,
    parameter int data_width_p = 32,
    parameter int gap_cycles_p = 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           req_v_i,
    input  logic [num_req_p*data_width_p-1:0] req_tag_i,
    output logic [num_req_p-1:0]           req_yumi_o,
    output logic [num_vcache_p-1:0]        print_stat_v_o,
    output logic [data_width_p-1:0]        print_stat_tag_o,
    output logic                           busy_o,
    output logic                           done_v_o
);

    localparam int idx_w = (num_vcache_p > 1) ? $clog2(num_vcache_p) : 1;
    localparam int gap_w = (gap_cycles_p > 0) ? $clog2(gap_cycles_p + 1) : 1;
    localparam int rr_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    localparam logic [idx_w-1:0]        last_idx = idx_w'(num_vcache_p - 1);
    localparam logic [rr_w:0]           nreq     = (rr_w + 1)'(num_req_p);
    localparam logic [num_req_p-1:0]    one_r    = num_req_p'(1);
    localparam logic [num_vcache_p-1:0] one_v    = num_vcache_p'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        DONE
    } state_e;

    state_e state, state_n;

    logic [idx_w-1:0]        idx, idx_n;
    logic [gap_w-1:0]        gap_cnt, gap_cnt_n;
    logic [rr_w-1:0]         rr_ptr, rr_ptr_n;
    logic [data_width_p-1:0] tag_r, tag_n;
    logic                    armed;

    logic                    found;
    logic                    take;
    logic [rr_w-1:0]         grant_w;
    logic [rr_w:0]           sum;
    logic [rr_w:0]           rr_inc;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        grant_w = '0;
        sum     = '0;
        for (int i = 0; i < num_req_p; i++) begin
            sum = {1'b0, rr_ptr} + (rr_w + 1)'(i);
            if (sum >= nreq) sum = sum - nreq;
            if (!found && req_v_i[sum[rr_w-1:0]]) begin
                found   = 1'b1;
                grant_w = sum[rr_w-1:0];
            end
        end
    end

    // No grant during reset or in the first cycle after it.
    assign take       = (state == IDLE) && armed && !reset_i && found;
    assign req_yumi_o = take ? (one_r << grant_w) : '0;

    always_comb begin
        state_n        = state;
        idx_n          = idx;
        gap_cnt_n      = gap_cnt;
        rr_ptr_n       = rr_ptr;
        tag_n          = tag_r;
        print_stat_v_o = '0;
        rr_inc         = '0;
        unique case (state)
            IDLE: begin
                if (take) begin
                    tag_n  = req_tag_i[int'(grant_w)*data_width_p +: data_width_p];
                    rr_inc = {1'b0, grant_w} + (rr_w + 1)'(1);
                    if (rr_inc >= nreq) rr_inc = rr_inc - nreq;
                    rr_ptr_n = rr_inc[rr_w-1:0];
                    idx_n    = '0;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                print_stat_v_o = one_v << idx;
                if (idx == last_idx) begin
                    state_n = DONE;
                end else if (gap_cycles_p == 0) begin
                    idx_n = idx + idx_w'(1);
                end else begin
                    gap_cnt_n = gap_w'(gap_cycles_p - 1);
                    idx_n     = idx + idx_w'(1);
                    state_n   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_n = ISSUE;
                else gap_cnt_n = gap_cnt - gap_w'(1);
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            rr_ptr  <= '0;
            tag_r   <= '0;
            armed   <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            gap_cnt <= gap_cnt_n;
            rr_ptr  <= rr_ptr_n;
            tag_r   <= tag_n;
            armed   <= 1'b1;
        end
    end

    assign print_stat_tag_o = tag_r;
    assign busy_o           = (state != IDLE);
    assign done_v_o         = (state == DONE);

endmodule
